// File: rtl/ucie_ctl_pkg.sv
// rtl/ucie_ctl_pkg.sv - shared FDI encodings, FSM state enum and defaults
// Purpose: FDI state_sts / state_req encodings and the protocol-side FSM
//          states used by the FDI lp driver, plus the flit-width default.
// Ports:   none (package)
package ucie_ctl_pkg;

   localparam int NBYTES_DEF = 64;

   // Adapter state status (pl_state_sts)
   localparam logic [3:0] STS_RESET     = 4'b0000;
   localparam logic [3:0] STS_ACTIVE    = 4'b0001;
   localparam logic [3:0] STS_LINKRESET = 4'b1001;
   localparam logic [3:0] STS_LINKERROR = 4'b1010;
   localparam logic [3:0] STS_RETRAIN   = 4'b1011;

   // Protocol state request (lp_state_req)
   localparam logic [3:0] REQ_NOP       = 4'b0000;
   localparam logic [3:0] REQ_ACTIVE    = 4'b0001;
   localparam logic [3:0] REQ_LINKRESET = 4'b1001;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ_ACTIVE,
      ST_ACTIVE,
      ST_RETRAIN_WAIT,
      ST_REQ_LINKRESET,
      ST_ERR,
      ST_WAIT_RESET
   } fdi_state_e;

   // State request presented while the FSM sits in a given state.
   function automatic logic [3:0] req_for_state(input fdi_state_e s);
      case (s)
         ST_REQ_ACTIVE,
         ST_ACTIVE,
         ST_RETRAIN_WAIT:  req_for_state = REQ_ACTIVE;
         ST_REQ_LINKRESET: req_for_state = REQ_LINKRESET;
         default:          req_for_state = REQ_NOP;
      endcase
   endfunction

endpackage

// File: rtl/ucie_ctl_sync_fifo.sv
// rtl/ucie_ctl_sync_fifo.sv - single-clock FIFO with synchronous flush
// Purpose: TX flit queue. Head is presented combinationally on o_data.
// Ports:   i_clk, i_rst (async, active-high)
//          i_push/i_data  write side (ignored when full)
//          i_pop          read side (ignored when empty)
//          i_flush        empties the queue, takes priority over push/pop
//          o_data         queue head
//          o_full/o_empty occupancy flags
module ucie_ctl_sync_fifo
   import ucie_ctl_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = NBYTES_DEF * 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   input  logic             i_flush,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ucie_ctl_fdi_lp_driver.sv
// rtl/ucie_ctl_fdi_lp_driver.sv - protocol-side FDI endpoint (bring-up, TX, RX, errors)
// Purpose: drives lp_state_req for link bring-up / LinkReset, acks the RX-active
//          handshake, streams queued application flits over lp_valid/lp_irdy/pl_trdy,
//          captures RX flits and escalates pl_error to lp_linkerror.
// Ports:   i_clk, i_rst (async, active-high)
//          i_start, i_linkreset_req        application control
//          i_app_data/i_app_valid/o_app_ready  application TX flits
//          i_pl_*                          adapter FDI inputs
//          o_lp_*                          FDI outputs toward the adapter
//          o_rx_data/o_rx_valid            captured RX flit
//          o_link_up, o_err_cnt            status
module ucie_ctl_fdi_lp_driver
   import ucie_ctl_pkg::*;
#(
   parameter int NBYTES = NBYTES_DEF,
   parameter int DEPTH  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_linkreset_req,
   input  logic [NBYTES*8-1:0]   i_app_data,
   input  logic                  i_app_valid,
   output logic                  o_app_ready,
   input  logic [3:0]            i_pl_state_sts,
   input  logic                  i_pl_inband_pres,
   input  logic                  i_pl_rx_active_req,
   input  logic                  i_pl_trdy,
   input  logic                  i_pl_error,
   input  logic [NBYTES*8-1:0]   i_pl_data,
   input  logic                  i_pl_valid,
   output logic [3:0]            o_lp_state_req,
   output logic                  o_lp_rx_active_sts,
   output logic                  o_lp_linkerror,
   output logic                  o_lp_irdy,
   output logic                  o_lp_valid,
   output logic [NBYTES*8-1:0]   o_lp_data,
   output logic [NBYTES*8-1:0]   o_rx_data,
   output logic                  o_rx_valid,
   output logic                  o_link_up,
   output logic [7:0]            o_err_cnt
);

   localparam int W = NBYTES * 8;

   fdi_state_e   r_state;
   fdi_state_e   w_state_nxt;
   logic [3:0]   r_state_req;
   logic         r_rx_active_sts;
   logic         r_pl_error_d;
   logic         r_rx_valid;
   logic [W-1:0] r_rx_data;
   logic [7:0]   r_err_cnt;
   logic         w_flush;
   logic         w_tx_valid;
   logic         w_tx_pop;
   logic         w_fifo_full;
   logic         w_fifo_empty;
   logic [W-1:0] w_fifo_head;

   // ---------------- FSM ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_IDLE;
         r_state_req <= REQ_NOP;
      end else begin
         r_state     <= w_state_nxt;
         r_state_req <= req_for_state(w_state_nxt);
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE:
            if (i_start && i_pl_inband_pres) w_state_nxt = ST_REQ_ACTIVE;
         ST_REQ_ACTIVE:
            if (i_pl_state_sts == STS_ACTIVE) w_state_nxt = ST_ACTIVE;
         ST_ACTIVE:
            if (i_linkreset_req)                    w_state_nxt = ST_REQ_LINKRESET;
            else if (i_pl_state_sts == STS_RETRAIN) w_state_nxt = ST_RETRAIN_WAIT;
            else if (i_pl_state_sts != STS_ACTIVE)  w_state_nxt = ST_WAIT_RESET;
         ST_RETRAIN_WAIT:
            if (i_pl_state_sts == STS_ACTIVE)      w_state_nxt = ST_ACTIVE;
            else if (i_pl_state_sts == STS_RESET)  w_state_nxt = ST_IDLE;
         ST_REQ_LINKRESET:
            if (i_pl_state_sts == STS_LINKRESET) w_state_nxt = ST_WAIT_RESET;
         ST_ERR:
            if (i_pl_state_sts == STS_LINKERROR) w_state_nxt = ST_WAIT_RESET;
         ST_WAIT_RESET:
            if (i_pl_state_sts == STS_RESET && !i_start) w_state_nxt = ST_IDLE;
         default:
            w_state_nxt = ST_IDLE;
      endcase
      // Adapter error overrides every other transition; ERR and WAIT_RESET
      // are already on the path to reset so they are left alone.
      if (i_pl_error && r_state != ST_ERR && r_state != ST_WAIT_RESET)
         w_state_nxt = ST_ERR;
   end

   // Queue is flushed only on the transition into ERR / WAIT_RESET.
   assign w_flush = (w_state_nxt != r_state) &&
                    (w_state_nxt == ST_ERR || w_state_nxt == ST_WAIT_RESET);

   // ---------------- TX path ----------------
   assign w_tx_valid = !w_fifo_empty && (r_state == ST_ACTIVE);
   assign w_tx_pop   = w_tx_valid && i_pl_trdy;

   ucie_ctl_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (W)
   ) u_tx_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (i_app_valid),
      .i_data  (i_app_data),
      .i_pop   (w_tx_pop),
      .i_flush (w_flush),
      .o_data  (w_fifo_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   // ---------------- RX-active ack, RX capture, error counter ----------------
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rx_active_sts <= 1'b0;
         r_pl_error_d    <= 1'b0;
         r_rx_valid      <= 1'b0;
         r_rx_data       <= '0;
         r_err_cnt       <= '0;
      end else begin
         r_rx_active_sts <= i_pl_rx_active_req;
         r_pl_error_d    <= i_pl_error;
         if (i_pl_valid && r_rx_active_sts && i_pl_state_sts == STS_ACTIVE) begin
            r_rx_data  <= i_pl_data;
            r_rx_valid <= 1'b1;
         end else begin
            r_rx_valid <= 1'b0;
         end
         if (i_pl_error && !r_pl_error_d && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
      end
   end

   assign o_app_ready        = !w_fifo_full;
   assign o_lp_state_req     = r_state_req;
   assign o_lp_rx_active_sts = r_rx_active_sts;
   assign o_lp_linkerror     = (r_state == ST_ERR);
   assign o_lp_irdy          = w_tx_valid;
   assign o_lp_valid         = w_tx_valid;
   assign o_lp_data          = w_fifo_head;
   assign o_rx_data          = r_rx_data;
   assign o_rx_valid         = r_rx_valid;
   assign o_link_up          = (r_state == ST_ACTIVE);
   assign o_err_cnt          = r_err_cnt;

endmodule

// File: tb/tb_ucie_ctl_fdi_lp_driver.sv
// tb/tb_ucie_ctl_fdi_lp_driver.sv - scoreboard bench for ucie_ctl_fdi_lp_driver
module tb_ucie_ctl_fdi_lp_driver;

   localparam int NB = 64;
   localparam int W  = NB * 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         linkreset_req = 1'b0;
   logic [W-1:0] app_data = '0;
   logic         app_valid = 1'b0;
   logic         app_ready;
   logic [3:0]   pl_state_sts = 4'b0000;
   logic         pl_inband_pres = 1'b0;
   logic         pl_rx_active_req = 1'b0;
   logic         pl_trdy = 1'b0;
   logic         pl_error = 1'b0;
   logic [W-1:0] pl_data = '0;
   logic         pl_valid = 1'b0;
   logic [3:0]   lp_state_req;
   logic         lp_rx_active_sts;
   logic         lp_linkerror;
   logic         lp_irdy;
   logic         lp_valid;
   logic [W-1:0] lp_data;
   logic [W-1:0] rx_data;
   logic         rx_valid;
   logic         link_up;
   logic [7:0]   err_cnt;

   int n_total = 0;
   int n_pass  = 0;
   int tx_beats = 0;
   logic [W-1:0] tx_q[$];
   logic [W-1:0] rx_q[$];

   ucie_ctl_fdi_lp_driver #(.NBYTES(NB), .DEPTH(4)) dut (
      .i_clk              (clk),
      .i_rst              (rst),
      .i_start            (start),
      .i_linkreset_req    (linkreset_req),
      .i_app_data         (app_data),
      .i_app_valid        (app_valid),
      .o_app_ready        (app_ready),
      .i_pl_state_sts     (pl_state_sts),
      .i_pl_inband_pres   (pl_inband_pres),
      .i_pl_rx_active_req (pl_rx_active_req),
      .i_pl_trdy          (pl_trdy),
      .i_pl_error         (pl_error),
      .i_pl_data          (pl_data),
      .i_pl_valid         (pl_valid),
      .o_lp_state_req     (lp_state_req),
      .o_lp_rx_active_sts (lp_rx_active_sts),
      .o_lp_linkerror     (lp_linkerror),
      .o_lp_irdy          (lp_irdy),
      .o_lp_valid         (lp_valid),
      .o_lp_data          (lp_data),
      .o_rx_data          (rx_data),
      .o_rx_valid         (rx_valid),
      .o_link_up          (link_up),
      .o_err_cnt          (err_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [W-1:0] flit(input logic [7:0] b);
      flit = {NB{b}};
   endfunction

   task automatic push_flit(input logic [7:0] b);
      chk("app_ready_before_push", app_ready, 1'b1);
      app_valid = 1'b1;
      app_data  = flit(b);
      tx_q.push_back(flit(b));
      tick();
      app_valid = 1'b0;
   endtask

   // TX scoreboard: a beat is accepted at the coming edge when valid && trdy.
   always @(negedge clk) begin
      if (!rst && lp_valid && pl_trdy) begin
         chk("tx_irdy_eq_valid", lp_irdy, lp_valid);
         chk("tx_sb_nonempty", tx_q.size() != 0, 1'b1);
         if (tx_q.size() != 0) chk("tx_data", lp_data, tx_q.pop_front());
         tx_beats++;
      end
   end

   // RX scoreboard
   always @(negedge clk) begin
      if (!rst && rx_valid) begin
         chk("rx_sb_nonempty", rx_q.size() != 0, 1'b1);
         if (rx_q.size() != 0) chk("rx_data", rx_data, rx_q.pop_front());
      end
   end

   initial begin
      int base;
      #3;
      chk("rst_req", lp_state_req, 4'b0000);
      chk("rst_app_ready", app_ready, 1'b1);
      chk("rst_link_up", link_up, 1'b0);
      chk("rst_lp_valid", lp_valid, 1'b0);
      chk("rst_err_cnt", err_cnt, 8'd0);
      chk("rst_rx_valid", rx_valid, 1'b0);
      chk("rst_linkerror", lp_linkerror, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Bring-up
      start = 1'b1; pl_inband_pres = 1'b1;
      chk("bringup_req_pre", lp_state_req, 4'b0000);
      tick();
      chk("bringup_req", lp_state_req, 4'b0001);
      chk("bringup_link_pre", link_up, 1'b0);
      pl_state_sts = 4'b0001;
      tick();
      chk("bringup_link_up", link_up, 1'b1);
      chk("bringup_no_tx", lp_valid, 1'b0);

      // TX backpressure: fill the queue with trdy low
      for (int i = 0; i < 4; i++) push_flit(8'hA0 + 8'(i));
      chk("full_app_ready", app_ready, 1'b0);
      chk("full_valid", lp_valid, 1'b1);
      for (int i = 0; i < 3; i++) begin
         chk("hold_data", lp_data, flit(8'hA0));
         tick();
      end
      base = tx_beats;
      pl_trdy = 1'b1;
      tick(4);
      chk("drain_beats", tx_beats - base, 4);
      chk("drain_empty", lp_valid, 1'b0);
      chk("drain_ready", app_ready, 1'b1);
      pl_trdy = 1'b0;

      // Retrain stalls TX but keeps req=Active
      push_flit(8'hE0);
      push_flit(8'hE1);
      pl_state_sts = 4'b1011;
      tick();
      chk("retrain_valid", lp_valid, 1'b0);
      chk("retrain_req", lp_state_req, 4'b0001);
      base = tx_beats;
      pl_trdy = 1'b1;
      tick(2);
      chk("retrain_no_beats", tx_beats - base, 0);
      pl_state_sts = 4'b0001;
      tick(3);
      chk("retrain_resume_beats", tx_beats - base, 2);
      chk("retrain_sb_empty", tx_q.size(), 0);
      pl_trdy = 1'b0;

      // Error escalation flushes the queue
      push_flit(8'hC0);
      push_flit(8'hC1);
      pl_error = 1'b1;
      tick();
      pl_error = 1'b0;
      tx_q.delete();
      chk("err_linkerror", lp_linkerror, 1'b1);
      chk("err_cnt_1", err_cnt, 8'd1);
      chk("err_valid", lp_valid, 1'b0);
      chk("err_flush_ready", app_ready, 1'b1);
      chk("err_req", lp_state_req, 4'b0000);
      pl_state_sts = 4'b1010;
      tick();
      chk("err_to_wait_reset", lp_linkerror, 1'b0);
      start = 1'b0; pl_state_sts = 4'b0000;
      tick();
      chk("wait_reset_req", lp_state_req, 4'b0000);
      start = 1'b1;
      tick();
      chk("idle_restart_req", lp_state_req, 4'b0001);
      linkreset_req = 1'b1;
      tick();
      linkreset_req = 1'b0;
      chk("linkreset_ignored", lp_state_req, 4'b0001);
      pl_state_sts = 4'b0001;
      tick();
      chk("err_relink", link_up, 1'b1);
      chk("err_flushed_tx", lp_valid, 1'b0);

      // LinkReset
      linkreset_req = 1'b1;
      tick();
      linkreset_req = 1'b0;
      chk("lr_req", lp_state_req, 4'b1001);
      chk("lr_link_down", link_up, 1'b0);
      pl_state_sts = 4'b1001;
      tick();
      chk("lr_wait_req", lp_state_req, 4'b0000);
      start = 1'b0; pl_state_sts = 4'b0000;
      tick();
      start = 1'b1;
      tick();
      chk("lr_idle_restart", lp_state_req, 4'b0001);
      pl_state_sts = 4'b0001;
      tick();
      chk("lr_relink", link_up, 1'b1);

      // RX-active handshake and capture
      chk("rxa_pre", lp_rx_active_sts, 1'b0);
      pl_rx_active_req = 1'b1;
      chk("rxa_not_yet", lp_rx_active_sts, 1'b0);
      tick();
      chk("rxa_ack", lp_rx_active_sts, 1'b1);
      pl_valid = 1'b1; pl_data = flit(8'h5A);
      rx_q.push_back(flit(8'h5A));
      tick();
      pl_valid = 1'b0;
      chk("rx_pulse", rx_valid, 1'b1);
      tick();
      chk("rx_pulse_end", rx_valid, 1'b0);
      pl_rx_active_req = 1'b0;
      chk("rxa_hold", lp_rx_active_sts, 1'b1);
      tick();
      chk("rxa_deassert", lp_rx_active_sts, 1'b0);
      pl_valid = 1'b1; pl_data = flit(8'hA5);
      tick();
      pl_valid = 1'b0;
      chk("rx_no_capture", rx_valid, 1'b0);
      chk("rx_data_held", rx_data, flit(8'h5A));

      // Asynchronous reset mid-transfer
      push_flit(8'hD0);
      chk("mid_valid", lp_valid, 1'b1);
      #2 rst = 1'b1;
      #1;
      tx_q.delete();
      chk("arst_valid", lp_valid, 1'b0);
      chk("arst_ready", app_ready, 1'b1);
      chk("arst_link", link_up, 1'b0);
      chk("arst_req", lp_state_req, 4'b0000);
      chk("arst_rx_data", rx_data, '0);
      chk("arst_err_cnt", err_cnt, 8'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      start = 1'b0;

      // Error counter saturation
      for (int i = 0; i < 260; i++) begin
         pl_error = 1'b1;
         tick();
         pl_error = 1'b0;
         tick();
         if (i == 253) chk("errcnt_254", err_cnt, 8'd254);
         if (i == 254) chk("errcnt_255", err_cnt, 8'd255);
      end
      chk("errcnt_sat", err_cnt, 8'd255);

      chk("tx_sb_drained", tx_q.size(), 0);
      chk("rx_sb_drained", rx_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
